// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared widths, FSM states and helpers for the SDRAM arbiter
package sdram_arb_pkg;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int DONE_GAP = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sdram_arb_if.sv
// sdram_arb_if: requester-side and controller-side signals around the arbiter
interface sdram_arb_if import sdram_arb_pkg::*; #(parameter int NPORTS = 3);
  logic [NPORTS*ADDR_W-1:0] p_addr;
  logic [NPORTS*DATA_W-1:0] p_din;
  logic [NPORTS*MASK_W-1:0] p_wmask;
  logic [NPORTS-1:0]        p_valid;
  logic                     p_urgent;
  logic [DATA_W-1:0]        p_dout;
  logic [NPORTS-1:0]        p_ready;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_din;
  logic [MASK_W-1:0]        mem_wmask;
  logic                     mem_valid;
  logic [DATA_W-1:0]        mem_dout;
  logic                     mem_ready;
  logic                     err;
  modport slave (
    input  p_addr, p_din, p_wmask, p_valid, p_urgent, mem_dout, mem_ready,
    output p_dout, p_ready, mem_addr, mem_din, mem_wmask, mem_valid, err
  );
  modport master (
    output p_addr, p_din, p_wmask, p_valid, p_urgent, mem_dout, mem_ready,
    input  p_dout, p_ready, mem_addr, mem_din, mem_wmask, mem_valid, err
  );
endinterface

// File: rtl/sdram_arb_rr_pick.sv
// rr_pick: combinational round-robin picker with a port 0 urgent override
module rr_pick import sdram_arb_pkg::*; #(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  input  logic          i_urgent,
  output logic [IW-1:0] o_grant,
  output logic          o_any
);
  logic [IW-1:0] w_rr;
  always_comb begin
    w_rr = '0;
    // descending scan so the port closest after i_last is written last and wins
    for (int k = N; k >= 1; k--) begin
      int j;
      j = (int'(i_last) + k) % N;
      if (i_req[IW'(j)]) w_rr = IW'(j);
    end
    o_grant = (i_urgent && i_req[0]) ? '0 : w_rr;
    o_any   = |i_req;
  end
endmodule

// File: rtl/sdram_arb.sv
// sdram_arb: shares one SDRAM controller port among NPORTS requesters, one transaction at a time
module sdram_arb import sdram_arb_pkg::*; #(
  parameter int NPORTS  = 3,
  parameter int TIMEOUT = 8192
) (
  input logic        clk,
  input logic        reset,
  sdram_arb_if.slave bus
);
  localparam int IW = idx_w(NPORTS);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t            r_state;
  logic [IW-1:0]     r_grant, r_last, w_grant;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              w_any, w_timeout;
  logic [ADDR_W-1:0] w_addr  [NPORTS];
  logic [DATA_W-1:0] w_din   [NPORTS];
  logic [MASK_W-1:0] w_wmask [NPORTS];
  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    assign w_addr[i]  = bus.p_addr[i*ADDR_W +: ADDR_W];
    assign w_din[i]   = bus.p_din[i*DATA_W +: DATA_W];
    assign w_wmask[i] = bus.p_wmask[i*MASK_W +: MASK_W];
  end
  rr_pick #(.N(NPORTS), .IW(IW)) u_pick (
    .i_req   (bus.p_valid),
    .i_last  (r_last),
    .i_urgent(bus.p_urgent),
    .o_grant (w_grant),
    .o_any   (w_any)
  );
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_timeout = w_cnt_nxt == CW'(TIMEOUT);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_last        <= IW'(NPORTS - 1);
      r_cnt         <= '0;
      bus.p_dout    <= '0;
      bus.p_ready   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_din   <= '0;
      bus.mem_wmask <= '0;
      bus.mem_valid <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.p_ready <= '0;
      case (r_state)
        IDLE: if (w_any) begin
          r_grant       <= w_grant;
          r_last        <= w_grant;
          r_cnt         <= '0;
          bus.mem_addr  <= w_addr[w_grant];
          bus.mem_din   <= w_din[w_grant];
          bus.mem_wmask <= w_wmask[w_grant];
          bus.mem_valid <= 1'b1;
          r_state       <= ISSUE;
        end
        ISSUE: begin
          r_cnt <= w_cnt_nxt;
          // a completion landing on the timeout cycle counts as a normal finish
          if (bus.mem_ready || w_timeout) begin
            bus.p_dout    <= bus.mem_ready ? bus.mem_dout : '0;
            bus.err       <= bus.err | ~bus.mem_ready;
            bus.p_ready   <= NPORTS'(1) << r_grant;
            bus.mem_valid <= 1'b0;
            r_state       <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: table-driven arbitration vectors plus corner sequences, checked through a completion scoreboard
module tb_sdram_arb;
  import sdram_arb_pkg::*;
  localparam int NP = 3;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sdram_arb_if #(.NPORTS(NP)) bus ();
  sdram_arb #(.NPORTS(NP), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct { logic [2:0] mask; logic urg; int lat; logic [31:0] dout; int port; } vec_t;
  typedef struct { int port; logic [31:0] dout; } exp_t;
  vec_t vecs[12];
  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  logic [24:0] a[NP];
  logic [31:0] d[NP];
  logic [3:0]  m[NP];
  logic        prev_v = 1'b0;
  bit          have_fall = 1'b0;
  int          low_cnt = 0;
  logic [60:0] cap;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic pack_ports();
    for (int i = 0; i < NP; i++) begin
      bus.p_addr[i*25 +: 25] = a[i];
      bus.p_din[i*32 +: 32]  = d[i];
      bus.p_wmask[i*4 +: 4]  = m[i];
    end
  endtask

  task automatic load();
    for (int i = 0; i < NP; i++) begin
      a[i] = 25'($urandom);
      d[i] = $urandom;
      m[i] = 4'($urandom);
    end
    pack_ports();
  endtask

  // lat < 0 means the controller never answers
  task automatic run_txn(input logic [2:0] mask, input logic urg, input int lat,
                         input logic [31:0] dout, input int port);
    int w = 0;
    int n = 1;
    @(posedge clk); #1;
    bus.p_valid = mask;
    bus.p_urgent = urg;
    while (!bus.mem_valid && w < 40) begin @(posedge clk); #1; w++; end
    if (!bus.mem_valid) begin
      chk("mem_valid wait", 0, 1);
      bus.p_valid = '0;
      return;
    end
    chk("mem_addr", bus.mem_addr, a[port]);
    chk("mem_din", bus.mem_din, d[port]);
    chk("mem_wmask", bus.mem_wmask, m[port]);
    if (lat >= 0) begin
      repeat (lat) @(posedge clk);
      #1;
      bus.mem_ready = 1'b1;
      bus.mem_dout = dout;
      sb.push_back('{port, dout});
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
    end else begin
      sb.push_back('{port, 32'h0});
      while (bus.mem_valid && n < 40) begin
        @(posedge clk); #1;
        if (bus.mem_valid) n++;
      end
      chk("issue cycles before timeout", n, TO);
    end
    chk("mem_valid low with p_ready", bus.mem_valid, 0);
    chk("p_ready grant", bus.p_ready, 64'(1) << port);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      have_fall = 1'b0;
      low_cnt = 0;
      prev_v = 1'b0;
    end else begin
      if (bus.mem_valid && !prev_v) begin
        if (have_fall) chk("mem_valid low gap", 64'(low_cnt >= DONE_GAP), 1);
        cap = {bus.mem_addr, bus.mem_din, bus.mem_wmask};
      end else if (bus.mem_valid) begin
        chk("request stable in ISSUE", {bus.mem_addr, bus.mem_din, bus.mem_wmask}, cap);
      end else if (prev_v) begin
        have_fall = 1'b1;
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      if (|bus.p_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected p_ready", bus.p_ready, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb p_ready", bus.p_ready, 64'(1) << mon_e.port);
          chk("sb p_dout", bus.p_dout, mon_e.dout);
        end
      end
      prev_v = bus.mem_valid;
    end
  end

  initial begin
    vecs[0]  = '{3'b111, 1'b0, 0,  32'h0000_1000, 0};
    vecs[1]  = '{3'b111, 1'b0, 1,  32'h0000_1001, 1};
    vecs[2]  = '{3'b111, 1'b0, 2,  32'h0000_1002, 2};
    vecs[3]  = '{3'b111, 1'b0, 3,  32'h0000_1003, 0};
    vecs[4]  = '{3'b111, 1'b0, 0,  32'h0000_1004, 1};
    vecs[5]  = '{3'b111, 1'b0, 1,  32'h0000_1005, 2};
    vecs[6]  = '{3'b010, 1'b0, 5,  32'hCAFE_F00D, 1};
    vecs[7]  = '{3'b111, 1'b1, 2,  32'h7777_0007, 0};
    vecs[8]  = '{3'b101, 1'b0, 1,  32'h8888_0008, 2};
    vecs[9]  = '{3'b110, 1'b1, 0,  32'h9999_0009, 1};
    vecs[10] = '{3'b001, 1'b0, 4,  32'hAAAA_000A, 0};
    vecs[11] = '{3'b001, 1'b0, 15, 32'hBBBB_000B, 0};
    bus.p_valid = '0;
    bus.p_urgent = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_dout = '0;
    load();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset mem_valid", bus.mem_valid, 0);
    chk("reset p_ready", bus.p_ready, 0);
    chk("reset p_dout", bus.p_dout, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_din", bus.mem_din, 0);
    chk("reset mem_wmask", bus.mem_wmask, 0);
    chk("reset err", bus.err, 0);
    foreach (vecs[i]) begin
      load();
      run_txn(vecs[i].mask, vecs[i].urg, vecs[i].lat, vecs[i].dout, vecs[i].port);
    end
    chk("err after ready on timeout cycle", bus.err, 0);
    load();
    run_txn(3'b010, 1'b0, -1, 32'h0, 1);
    chk("err after timeout", bus.err, 1);
    load();
    run_txn(3'b100, 1'b0, 2, 32'h1234_5678, 2);
    chk("err sticky", bus.err, 1);
    a[2] = 25'h1ABCDE;
    m[2] = 4'b0011;
    d[2] = 32'h5A5A_1234;
    pack_ports();
    run_txn(3'b100, 1'b0, 6, 32'h0BAD_0BAD, 2);
    @(posedge clk); #1;
    bus.p_valid = 3'b001;
    for (int w = 0; w < 40 && !bus.mem_valid; w++) begin @(posedge clk); #1; end
    chk("mem_valid before reset", bus.mem_valid, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.p_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid-issue reset mem_valid", bus.mem_valid, 0);
    chk("mid-issue reset p_ready", bus.p_ready, 0);
    chk("mid-issue reset err", bus.err, 0);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("idle mem_ready p_ready", bus.p_ready, 0);
    chk("idle mem_ready mem_valid", bus.mem_valid, 0);
    load();
    run_txn(3'b011, 1'b0, 2, 32'h0F0F_F0F0, 0);
    @(posedge clk); #1;
    bus.p_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
